stg4mem: RTL and testbench

- Memory-access pipeline stage, directly upstream of the writeback stage.
- Passes ALU results through in one cycle.
- Load/store instructions perform a single req/ack transaction on the data-memory port; the pipeline stalls until the transaction completes.
- Registered outputs present a completed instruction, or a zero bubble, to writeback on every cycle.

---
 rtl/stg4mem_pkg.sv | 15 +
 rtl/stg4mem_hold.sv | 58 +++++
 rtl/stg4mem.sv | 205 ++++++++++++++++++++
 tb/tb_stg4mem.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stg4mem_pkg.sv
// rtl/stg4mem_pkg.sv - shared widths and FSM encoding for the memory-access stage
package stg4mem_pkg;

    localparam int ADDR_W_DEF   = 24;
    localparam int DATA_W_DEF   = 24;
    localparam int OPC_W_DEF    = 8;
    localparam int TGT_GP_W_DEF = 4;
    localparam int TGT_SR_W_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/stg4mem_hold.sv
// rtl/stg4mem_hold.sv - capture registers for the instruction waiting on data memory
module stg4mem_hold
    import stg4mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OPC_W    = OPC_W_DEF,
    parameter int TGT_GP_W = TGT_GP_W_DEF,
    parameter int TGT_SR_W = TGT_SR_W_DEF
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_ld,
    input  logic [ADDR_W-1:0]   iw_pc,
    input  logic [DATA_W-1:0]   iw_instr,
    input  logic [OPC_W-1:0]    iw_opc,
    input  logic [TGT_GP_W-1:0] iw_tgt_gp,
    input  logic                iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0] iw_tgt_sr,
    input  logic                iw_tgt_sr_we,
    input  logic [DATA_W-1:0]   iw_result,
    input  logic                iw_is_load,
    output logic [ADDR_W-1:0]   ow_pc,
    output logic [DATA_W-1:0]   ow_instr,
    output logic [OPC_W-1:0]    ow_opc,
    output logic [TGT_GP_W-1:0] ow_tgt_gp,
    output logic                ow_tgt_gp_we,
    output logic [TGT_SR_W-1:0] ow_tgt_sr,
    output logic                ow_tgt_sr_we,
    output logic [DATA_W-1:0]   ow_result,
    output logic                ow_is_load
);

    localparam int HOLD_W = ADDR_W + 2*DATA_W + OPC_W + TGT_GP_W + TGT_SR_W + 3;

    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_q;

    always_comb begin
        hold_d = hold_q;
        if (iw_ld) begin
            hold_d = {iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_gp_we,
                      iw_tgt_sr, iw_tgt_sr_we, iw_result, iw_is_load};
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign {ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we,
            ow_tgt_sr, ow_tgt_sr_we, ow_result, ow_is_load} = hold_q;

endmodule

// File: rtl/stg4mem.sv
// rtl/stg4mem.sv - memory-access pipeline stage; STG4MEM_TIMEOUT_EN adds an ack watchdog
module stg4mem
    import stg4mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int OPC_W          = OPC_W_DEF,
    parameter int TGT_GP_W       = TGT_GP_W_DEF,
    parameter int TGT_SR_W       = TGT_SR_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_valid,
    output logic                ow_stall,
    input  logic [ADDR_W-1:0]   iw_pc,
    input  logic [DATA_W-1:0]   iw_instr,
    input  logic [OPC_W-1:0]    iw_opc,
    input  logic [TGT_GP_W-1:0] iw_tgt_gp,
    input  logic                iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0] iw_tgt_sr,
    input  logic                iw_tgt_sr_we,
    input  logic [DATA_W-1:0]   iw_result,
    input  logic [ADDR_W-1:0]   iw_mem_addr,
    input  logic [DATA_W-1:0]   iw_store_data,
    input  logic                iw_is_load,
    input  logic                iw_is_store,
    output logic                ow_mem_req,
    output logic                ow_mem_we,
    output logic [ADDR_W-1:0]   ow_mem_addr,
    output logic [DATA_W-1:0]   ow_mem_wdata,
    input  logic                iw_mem_ack,
    input  logic [DATA_W-1:0]   iw_mem_rdata,
    output logic                ow_valid,
    output logic [ADDR_W-1:0]   ow_pc,
    output logic [DATA_W-1:0]   ow_instr,
    output logic [OPC_W-1:0]    ow_opc,
    output logic [TGT_GP_W-1:0] ow_tgt_gp,
    output logic                ow_tgt_gp_we,
    output logic [TGT_SR_W-1:0] ow_tgt_sr,
    output logic                ow_tgt_sr_we,
    output logic [DATA_W-1:0]   ow_result
`ifdef STG4MEM_TIMEOUT_EN
    ,
    output logic                ow_mem_fault
`endif
);

    localparam int WB_W = 1 + ADDR_W + 2*DATA_W + OPC_W + TGT_GP_W + TGT_SR_W + 2;

    state_t              state_d, state_q;
    logic [WB_W-1:0]     wb_d, wb_q;
    logic                mem_req_d, mem_req_q;
    logic                mem_we_d, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
    logic                hold_ld;
    logic                mem_op;
    logic                tmo_hit;

    logic [ADDR_W-1:0]   h_pc;
    logic [DATA_W-1:0]   h_instr;
    logic [OPC_W-1:0]    h_opc;
    logic [TGT_GP_W-1:0] h_tgt_gp;
    logic                h_tgt_gp_we;
    logic [TGT_SR_W-1:0] h_tgt_sr;
    logic                h_tgt_sr_we;
    logic [DATA_W-1:0]   h_result;
    logic                h_is_load;

    assign mem_op = iw_is_load | iw_is_store;

`ifdef STG4MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             fault_d, fault_q;

    // cnt_q counts completed WAIT cycles, so the hit fires in the TIMEOUT_CYCLES-th one
    assign tmo_hit      = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ow_mem_fault = fault_q;
`else
    assign tmo_hit = 1'b0;
`endif

    stg4mem_hold #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OPC_W    (OPC_W),
        .TGT_GP_W (TGT_GP_W),
        .TGT_SR_W (TGT_SR_W)
    ) u_hold (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_ld        (hold_ld),
        .iw_pc        (iw_pc),
        .iw_instr     (iw_instr),
        .iw_opc       (iw_opc),
        .iw_tgt_gp    (iw_tgt_gp),
        .iw_tgt_gp_we (iw_tgt_gp_we),
        .iw_tgt_sr    (iw_tgt_sr),
        .iw_tgt_sr_we (iw_tgt_sr_we),
        .iw_result    (iw_result),
        .iw_is_load   (iw_is_load),
        .ow_pc        (h_pc),
        .ow_instr     (h_instr),
        .ow_opc       (h_opc),
        .ow_tgt_gp    (h_tgt_gp),
        .ow_tgt_gp_we (h_tgt_gp_we),
        .ow_tgt_sr    (h_tgt_sr),
        .ow_tgt_sr_we (h_tgt_sr_we),
        .ow_result    (h_result),
        .ow_is_load   (h_is_load)
    );

    always_comb begin
        state_d     = state_q;
        wb_d        = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_ld     = 1'b0;
`ifdef STG4MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (iw_valid && mem_op) begin
                    hold_ld     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = iw_is_store & ~iw_is_load;
                    mem_addr_d  = iw_mem_addr;
                    mem_wdata_d = iw_store_data;
                    state_d     = WAIT;
`ifdef STG4MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (iw_valid) begin
                    wb_d = {1'b1, iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_gp_we,
                            iw_tgt_sr, iw_tgt_sr_we, iw_result};
                end
            end
            WAIT: begin
                if (iw_mem_ack) begin
                    wb_d = {1'b1, h_pc, h_instr, h_opc, h_tgt_gp, h_tgt_gp_we,
                            h_tgt_sr, h_tgt_sr_we, h_is_load ? iw_mem_rdata : h_result};
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
`ifdef STG4MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q     <= IDLE;
            wb_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef STG4MEM_TIMEOUT_EN
            cnt_q       <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wb_q        <= wb_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef STG4MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
`endif
        end
    end

    // Upstream advances on the ack (or abort) edge, so stall drops combinationally there
    assign ow_stall = ~iw_rst & ((state_q == IDLE) ? (iw_valid & mem_op)
                                                   : (~iw_mem_ack & ~tmo_hit));

    assign {ow_valid, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we,
            ow_tgt_sr, ow_tgt_sr_we, ow_result} = wb_q;
    assign ow_mem_req   = mem_req_q;
    assign ow_mem_we    = mem_we_q;
    assign ow_mem_addr  = mem_addr_q;
    assign ow_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stg4mem.sv
// tb/tb_stg4mem.sv - directed self-checking bench for stg4mem
module tb_stg4mem;

    logic        clk;
    logic        rst;
    logic        iw_valid;
    logic        ow_stall;
    logic [23:0] iw_pc, iw_instr, iw_result, iw_mem_addr, iw_store_data, iw_mem_rdata;
    logic [7:0]  iw_opc;
    logic [3:0]  iw_tgt_gp;
    logic        iw_tgt_gp_we;
    logic [1:0]  iw_tgt_sr;
    logic        iw_tgt_sr_we;
    logic        iw_is_load, iw_is_store, iw_mem_ack;
    logic        ow_mem_req, ow_mem_we;
    logic [23:0] ow_mem_addr, ow_mem_wdata;
    logic        ow_valid;
    logic [23:0] ow_pc, ow_instr, ow_result;
    logic [7:0]  ow_opc;
    logic [3:0]  ow_tgt_gp;
    logic        ow_tgt_gp_we;
    logic [1:0]  ow_tgt_sr;
    logic        ow_tgt_sr_we;
`ifdef STG4MEM_TIMEOUT_EN
    logic        ow_mem_fault;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    stg4mem #(.TIMEOUT_CYCLES(4)) dut (
        .iw_clk        (clk),
        .iw_rst        (rst),
        .iw_valid      (iw_valid),
        .ow_stall      (ow_stall),
        .iw_pc         (iw_pc),
        .iw_instr      (iw_instr),
        .iw_opc        (iw_opc),
        .iw_tgt_gp     (iw_tgt_gp),
        .iw_tgt_gp_we  (iw_tgt_gp_we),
        .iw_tgt_sr     (iw_tgt_sr),
        .iw_tgt_sr_we  (iw_tgt_sr_we),
        .iw_result     (iw_result),
        .iw_mem_addr   (iw_mem_addr),
        .iw_store_data (iw_store_data),
        .iw_is_load    (iw_is_load),
        .iw_is_store   (iw_is_store),
        .ow_mem_req    (ow_mem_req),
        .ow_mem_we     (ow_mem_we),
        .ow_mem_addr   (ow_mem_addr),
        .ow_mem_wdata  (ow_mem_wdata),
        .iw_mem_ack    (iw_mem_ack),
        .iw_mem_rdata  (iw_mem_rdata),
        .ow_valid      (ow_valid),
        .ow_pc         (ow_pc),
        .ow_instr      (ow_instr),
        .ow_opc        (ow_opc),
        .ow_tgt_gp     (ow_tgt_gp),
        .ow_tgt_gp_we  (ow_tgt_gp_we),
        .ow_tgt_sr     (ow_tgt_sr),
        .ow_tgt_sr_we  (ow_tgt_sr_we),
        .ow_result     (ow_result)
`ifdef STG4MEM_TIMEOUT_EN
        ,
        .ow_mem_fault  (ow_mem_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_clear();
        iw_valid = 0; iw_pc = '0; iw_instr = '0; iw_opc = '0;
        iw_tgt_gp = '0; iw_tgt_gp_we = 0; iw_tgt_sr = '0; iw_tgt_sr_we = 0;
        iw_result = '0; iw_mem_addr = '0; iw_store_data = '0;
        iw_is_load = 0; iw_is_store = 0; iw_mem_ack = 0; iw_mem_rdata = '0;
    endtask

    task automatic test_reset();
        drive_clear();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({ow_valid, ow_mem_req, ow_mem_we, ow_pc, ow_result, ow_mem_addr} !== '0)
            $display("FAIL reset_outputs: got %b/%b/%b pc=%h res=%h addr=%h expected all zero",
                     ow_valid, ow_mem_req, ow_mem_we, ow_pc, ow_result, ow_mem_addr);
        else pass_cnt++;
        iw_valid = 1; iw_is_load = 1;
        #1;
        total_cnt++;
        if (ow_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", ow_stall);
        else pass_cnt++;
        drive_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_pass();
        drive_clear();
        iw_valid = 1; iw_pc = 24'h000010; iw_instr = 24'h0A0B0C; iw_opc = 8'h21;
        iw_tgt_gp = 4'd3; iw_tgt_gp_we = 1; iw_tgt_sr = 2'd2; iw_tgt_sr_we = 1;
        iw_result = 24'h00ABCD;
        #1;
        total_cnt++;
        if (ow_stall !== 1'b0) $display("FAIL alu_stall: got %b expected 0", ow_stall);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ow_valid, ow_result, ow_tgt_gp, ow_tgt_gp_we} !== {1'b1, 24'h00ABCD, 4'd3, 1'b1})
            $display("FAIL alu_wb: got v=%b res=%h gp=%h we=%b expected v=1 res=00abcd gp=3 we=1",
                     ow_valid, ow_result, ow_tgt_gp, ow_tgt_gp_we);
        else pass_cnt++;
        total_cnt++;
        if ({ow_pc, ow_instr, ow_opc, ow_tgt_sr, ow_tgt_sr_we} !== {24'h000010, 24'h0A0B0C, 8'h21, 2'd2, 1'b1})
            $display("FAIL alu_fields: got pc=%h instr=%h opc=%h sr=%h srwe=%b expected 000010 0a0b0c 21 2 1",
                     ow_pc, ow_instr, ow_opc, ow_tgt_sr, ow_tgt_sr_we);
        else pass_cnt++;
        drive_clear();
        tick();
        total_cnt++;
        if ({ow_valid, ow_tgt_gp_we, ow_tgt_sr_we, ow_result} !== '0)
            $display("FAIL alu_bubble: got v=%b gpwe=%b srwe=%b res=%h expected zeros",
                     ow_valid, ow_tgt_gp_we, ow_tgt_sr_we, ow_result);
        else pass_cnt++;
    endtask

    task automatic test_load();
        drive_clear();
        iw_valid = 1; iw_is_load = 1; iw_pc = 24'h000040; iw_mem_addr = 24'h000200;
        iw_tgt_gp = 4'd5; iw_tgt_gp_we = 1; iw_result = 24'h000999;
        #1;
        total_cnt++;
        if (ow_stall !== 1'b1) $display("FAIL load_stall_accept: got %b expected 1", ow_stall);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({ow_mem_req, ow_mem_we, ow_mem_addr, ow_valid} !== {1'b1, 1'b0, 24'h000200, 1'b0})
                $display("FAIL load_wait%0d: got req=%b we=%b addr=%h v=%b expected req=1 we=0 addr=000200 v=0",
                         k, ow_mem_req, ow_mem_we, ow_mem_addr, ow_valid);
            else pass_cnt++;
            if (k == 2) begin
                iw_mem_ack = 1; iw_mem_rdata = 24'h123456;
            end
            #1;
            total_cnt++;
            if (ow_stall !== (k != 2))
                $display("FAIL load_stall%0d: got %b expected %b", k, ow_stall, (k != 2));
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({ow_valid, ow_pc, ow_result, ow_tgt_gp, ow_tgt_gp_we} !== {1'b1, 24'h000040, 24'h123456, 4'd5, 1'b1})
            $display("FAIL load_wb: got v=%b pc=%h res=%h gp=%h we=%b expected 1 000040 123456 5 1",
                     ow_valid, ow_pc, ow_result, ow_tgt_gp, ow_tgt_gp_we);
        else pass_cnt++;
        total_cnt++;
        if ({ow_mem_req, ow_mem_we} !== 2'b00)
            $display("FAIL load_req_drop: got req=%b we=%b expected 0 0", ow_mem_req, ow_mem_we);
        else pass_cnt++;
        drive_clear();
        tick();
        total_cnt++;
        if (ow_valid !== 1'b0) $display("FAIL load_no_dup: got v=%b expected 0", ow_valid);
        else pass_cnt++;
    endtask

    task automatic test_store();
        drive_clear();
        iw_valid = 1; iw_is_store = 1; iw_pc = 24'h000050; iw_mem_addr = 24'h000300;
        iw_store_data = 24'h00FFEE; iw_tgt_gp = 4'd7; iw_tgt_gp_we = 0; iw_result = 24'h000777;
        tick();
        total_cnt++;
        if ({ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_valid} !== {1'b1, 1'b1, 24'h000300, 24'h00FFEE, 1'b0})
            $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h v=%b expected 1 1 000300 00ffee 0",
                     ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_valid);
        else pass_cnt++;
        iw_mem_ack = 1;
        #1;
        total_cnt++;
        if (ow_stall !== 1'b0) $display("FAIL store_stall_ack: got %b expected 0", ow_stall);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ow_valid, ow_pc, ow_result, ow_tgt_gp_we, ow_mem_req, ow_mem_we} !== {1'b1, 24'h000050, 24'h000777, 1'b0, 1'b0, 1'b0})
            $display("FAIL store_wb: got v=%b pc=%h res=%h gpwe=%b req=%b we=%b expected 1 000050 000777 0 0 0",
                     ow_valid, ow_pc, ow_result, ow_tgt_gp_we, ow_mem_req, ow_mem_we);
        else pass_cnt++;
        drive_clear();
    endtask

    task automatic test_load_store_both();
        drive_clear();
        iw_valid = 1; iw_is_load = 1; iw_is_store = 1; iw_pc = 24'h000058;
        iw_mem_addr = 24'h000310; iw_result = 24'h000001; iw_tgt_gp = 4'd1; iw_tgt_gp_we = 1;
        tick();
        total_cnt++;
        if ({ow_mem_req, ow_mem_we} !== 2'b10)
            $display("FAIL both_we: got req=%b we=%b expected 1 0", ow_mem_req, ow_mem_we);
        else pass_cnt++;
        iw_mem_ack = 1; iw_mem_rdata = 24'h0F0F0F;
        tick();
        total_cnt++;
        if ({ow_valid, ow_result} !== {1'b1, 24'h0F0F0F})
            $display("FAIL both_result: got v=%b res=%h expected 1 0f0f0f", ow_valid, ow_result);
        else pass_cnt++;
        drive_clear();
    endtask

    task automatic test_back_to_back();
        drive_clear();
        iw_valid = 1; iw_is_load = 1; iw_pc = 24'h000060; iw_mem_addr = 24'h000400;
        iw_tgt_gp = 4'd2; iw_tgt_gp_we = 1;
        tick();
        iw_mem_ack = 1; iw_mem_rdata = 24'h0A0B0C;
        tick();
        total_cnt++;
        if ({ow_valid, ow_pc, ow_result} !== {1'b1, 24'h000060, 24'h0A0B0C})
            $display("FAIL b2b_load: got v=%b pc=%h res=%h expected 1 000060 0a0b0c", ow_valid, ow_pc, ow_result);
        else pass_cnt++;
        drive_clear();
        iw_valid = 1; iw_pc = 24'h000064; iw_result = 24'h111111; iw_tgt_gp = 4'd4; iw_tgt_gp_we = 1;
        #1;
        total_cnt++;
        if (ow_stall !== 1'b0) $display("FAIL b2b_stall: got %b expected 0", ow_stall);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({ow_valid, ow_pc, ow_result, ow_tgt_gp} !== {1'b1, 24'h000064, 24'h111111, 4'd4})
            $display("FAIL b2b_alu: got v=%b pc=%h res=%h gp=%h expected 1 000064 111111 4",
                     ow_valid, ow_pc, ow_result, ow_tgt_gp);
        else pass_cnt++;
        drive_clear();
        tick();
        total_cnt++;
        if (ow_valid !== 1'b0) $display("FAIL b2b_no_dup: got v=%b expected 0", ow_valid);
        else pass_cnt++;
    endtask

    task automatic test_ack_idle();
        drive_clear();
        iw_mem_ack = 1; iw_mem_rdata = 24'hFFFFFF;
        tick();
        total_cnt++;
        if ({ow_valid, ow_mem_req, ow_result, ow_stall} !== '0)
            $display("FAIL ack_idle: got v=%b req=%b res=%h stall=%b expected zeros",
                     ow_valid, ow_mem_req, ow_result, ow_stall);
        else pass_cnt++;
        drive_clear();
    endtask

    task automatic test_reset_mid();
        drive_clear();
        iw_valid = 1; iw_is_store = 1; iw_pc = 24'h000080; iw_mem_addr = 24'h000500;
        iw_store_data = 24'h00BEEF; iw_tgt_gp_we = 1;
        tick();
        total_cnt++;
        if (ow_mem_req !== 1'b1) $display("FAIL rstmid_req: got %b expected 1", ow_mem_req);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_valid, ow_stall} !== '0)
            $display("FAIL rstmid_async: got req=%b we=%b addr=%h wd=%h v=%b stall=%b expected zeros",
                     ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_valid, ow_stall);
        else pass_cnt++;
        drive_clear();
        @(negedge clk);
        rst = 1'b0;
        iw_mem_ack = 1; iw_mem_rdata = 24'h555555;
        tick();
        total_cnt++;
        if ({ow_valid, ow_mem_req, ow_result} !== '0)
            $display("FAIL rstmid_late_ack: got v=%b req=%b res=%h expected zeros", ow_valid, ow_mem_req, ow_result);
        else pass_cnt++;
        drive_clear();
    endtask

`ifdef STG4MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_clear();
        iw_valid = 1; iw_is_load = 1; iw_pc = 24'h000090; iw_mem_addr = 24'h000600; iw_tgt_gp_we = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total_cnt++;
            if ({ow_mem_req, ow_mem_fault} !== 2'b10)
                $display("FAIL tmo_wait%0d: got req=%b fault=%b expected 1 0", k, ow_mem_req, ow_mem_fault);
            else pass_cnt++;
            total_cnt++;
            if (ow_stall !== (k != 3))
                $display("FAIL tmo_stall%0d: got %b expected %b", k, ow_stall, (k != 3));
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({ow_mem_fault, ow_mem_req, ow_valid} !== 3'b100)
            $display("FAIL tmo_abort: got fault=%b req=%b v=%b expected 1 0 0", ow_mem_fault, ow_mem_req, ow_valid);
        else pass_cnt++;
        drive_clear();
        iw_valid = 1; iw_pc = 24'h000070; iw_result = 24'h222222;
        tick();
        total_cnt++;
        if ({ow_mem_fault, ow_valid, ow_pc, ow_result} !== {1'b0, 1'b1, 24'h000070, 24'h222222})
            $display("FAIL tmo_recover: got fault=%b v=%b pc=%h res=%h expected 0 1 000070 222222",
                     ow_mem_fault, ow_valid, ow_pc, ow_result);
        else pass_cnt++;
        drive_clear();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_load_store_both();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid();
`ifdef STG4MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
